// File: rtl/sin_sweep_ctrl_if.sv
// Sweep controller bus: request/config from the sequencer, drive to the sine source.
//   master : sequencer side, drives start/abort and the sweep configuration
//   slave  : sin_sweep_ctrl side, drives freq_word/amp_out/src_en and status
interface sin_sweep_ctrl_if #(
  parameter int unsigned FW = 16,
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16
);
  logic          start;
  logic          abort;
  logic [FW-1:0] start_freq;
  logic [FW-1:0] step;
  logic [7:0]    num_steps;
  logic [DW-1:0] dwell;
  logic [AW-1:0] amp;

  logic [FW-1:0] freq_word;
  logic [AW-1:0] amp_out;
  logic          src_en;
  logic          step_strobe;
  logic          busy;
  logic          done;

  modport master (
    output start, abort, start_freq, step, num_steps, dwell, amp,
    input  freq_word, amp_out, src_en, step_strobe, busy, done
  );

  modport slave (
    input  start, abort, start_freq, step, num_steps, dwell, amp,
    output freq_word, amp_out, src_en, step_strobe, busy, done
  );
endinterface

// File: rtl/sin_sweep_ctrl.sv
// Frequency sweep controller for a sine source.
// On start (in idle) the configuration is captured, amplitude ramps 0 -> amp one code per
// cycle, the tuning word is held for max(dwell,1) cycles at each of num_steps+1 frequencies
// (saturating increments), then amplitude ramps back to 0 and done pulses.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - sin_sweep_ctrl_if.slave: start/abort/config in, freq_word/amp_out/src_en,
//          step_strobe/busy/done out (all outputs registered)
module sin_sweep_ctrl #(
  parameter int unsigned FW = 16,
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16
) (
  input  logic              clk,
  input  logic              rst,
  sin_sweep_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    StIdle,
    StRampUp,
    StDwell,
    StStep,
    StRampDown,
    StDone
  } state_e;

  state_e        state_q;
  logic [FW-1:0] step_q;
  logic [7:0]    num_steps_q;
  logic [7:0]    idx_q;
  logic [DW-1:0] dwell_q;
  logic [DW-1:0] cnt_q;
  logic [AW-1:0] amp_q;

  // Dwell counter counts down to zero, so a dwell of 0 behaves like 1.
  logic [DW-1:0] dwell_load;
  assign dwell_load = (dwell_q == '0) ? '0 : dwell_q - DW'(1);

  // One extra bit catches the carry so the increment saturates at all-ones.
  logic [FW:0]   freq_sum;
  logic [FW-1:0] freq_next;
  assign freq_sum  = {1'b0, bus.freq_word} + {1'b0, step_q};
  assign freq_next = freq_sum[FW] ? '1 : freq_sum[FW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      step_q          <= '0;
      num_steps_q     <= '0;
      idx_q           <= '0;
      dwell_q         <= '0;
      cnt_q           <= '0;
      amp_q           <= '0;
      bus.freq_word   <= '0;
      bus.amp_out     <= '0;
      bus.src_en      <= 1'b0;
      bus.step_strobe <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
    end else begin
      bus.step_strobe <= 1'b0;
      bus.done        <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start && !bus.abort) begin
            step_q        <= bus.step;
            num_steps_q   <= bus.num_steps;
            dwell_q       <= bus.dwell;
            amp_q         <= bus.amp;
            idx_q         <= '0;
            bus.freq_word <= bus.start_freq;
            bus.amp_out   <= '0;
            bus.src_en    <= 1'b1;
            bus.busy      <= 1'b1;
            state_q       <= StRampUp;
          end
        end
        StRampUp: begin
          if (bus.abort) begin
            state_q <= StRampDown;
          end else if (bus.amp_out == amp_q) begin
            cnt_q   <= dwell_load;
            state_q <= StDwell;
          end else begin
            bus.amp_out <= bus.amp_out + AW'(1);
          end
        end
        StDwell: begin
          if (bus.abort) begin
            state_q <= StRampDown;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - DW'(1);
          end else if (idx_q < num_steps_q) begin
            // New frequency and strobe become visible together in the STEP cycle.
            bus.freq_word   <= freq_next;
            bus.step_strobe <= 1'b1;
            idx_q           <= idx_q + 8'd1;
            state_q         <= StStep;
          end else begin
            state_q <= StRampDown;
          end
        end
        StStep: begin
          if (bus.abort) begin
            state_q <= StRampDown;
          end else begin
            cnt_q   <= dwell_load;
            state_q <= StDwell;
          end
        end
        StRampDown: begin
          if (bus.amp_out == '0) begin
            bus.src_en <= 1'b0;
            bus.done   <= 1'b1;
            state_q    <= StDone;
          end else begin
            bus.amp_out <= bus.amp_out - AW'(1);
          end
        end
        StDone: begin
          bus.busy <= 1'b0;
          state_q  <= StIdle;
        end
        default: begin
          bus.src_en  <= 1'b0;
          bus.busy    <= 1'b0;
          bus.amp_out <= '0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sin_sweep_ctrl.sv
module tb_sin_sweep_ctrl;

  localparam int PhUp    = 0;
  localparam int PhDwell = 1;
  localparam int PhStep  = 2;
  localparam int PhDown  = 3;
  localparam int PhDone  = 4;
  localparam int PhIdle  = 5;

  typedef struct {
    logic [15:0] freq;
    logic [7:0]  amp;
    logic        src_en;
    logic        strobe;
    logic        busy;
    logic        done;
    int          ph;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t exp_q[$];
  logic [15:0] last_freq;

  sin_sweep_ctrl_if #(.FW(16), .AW(8), .DW(16)) bus ();

  sin_sweep_ctrl #(.FW(16), .AW(8), .DW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  function automatic logic [27:0] observed();
    return {bus.freq_word, bus.amp_out, bus.src_en, bus.step_strobe, bus.busy, bus.done};
  endfunction

  function automatic logic [27:0] packed_exp(input exp_t e);
    return {e.freq, e.amp, e.src_en, e.strobe, e.busy, e.done};
  endfunction

  // Reference model: one entry per clock cycle after the start edge.
  function automatic void push(input int ph, input int f, input int a);
    exp_t e;
    e.ph     = ph;
    e.freq   = 16'(f);
    e.amp    = 8'(a);
    e.src_en = (ph == PhUp || ph == PhDwell || ph == PhStep || ph == PhDown);
    e.strobe = (ph == PhStep);
    e.busy   = (ph != PhIdle);
    e.done   = (ph == PhDone);
    exp_q.push_back(e);
  endfunction

  function automatic void push_tail(input int f, input int a);
    for (int k = a; k >= 0; k--) push(PhDown, f, k);
    push(PhDone, f, 0);
    push(PhIdle, f, 0);
  endfunction

  function automatic void build_sweep(input int sf, input int st, input int ns, input int dw,
                                      input int a);
    int f;
    int d;
    exp_q.delete();
    for (int k = 0; k <= a; k++) push(PhUp, sf, k);
    f = sf;
    d = (dw == 0) ? 1 : dw;
    for (int k = 0; k <= ns; k++) begin
      for (int j = 0; j < d; j++) push(PhDwell, f, a);
      if (k < ns) begin
        f = f + st;
        if (f > 65535) f = 65535;
        push(PhStep, f, a);
      end
    end
    push_tail(f, a);
  endfunction

  task automatic drive_cfg_random();
    bus.start_freq = 16'($urandom);
    bus.step       = 16'($urandom);
    bus.num_steps  = 8'($urandom);
    bus.dwell      = 16'($urandom);
    bus.amp        = 8'($urandom);
  endtask

  // abort_sel: -1 none, -2 random cycle, otherwise the cycle index that carries abort.
  task automatic run_sweep(input string name, input int sf, input int st, input int ns,
                           input int dw, input int a, input int abort_sel, input bit noise,
                           input bit rst_on_step);
    int abort_at;
    int i;
    bit ab;
    build_sweep(sf, st, ns, dw, a);
    abort_at = abort_sel;
    if (abort_sel == -2) abort_at = $urandom_range(0, exp_q.size() - 2);
    bus.start_freq = 16'(sf);
    bus.step       = 16'(st);
    bus.num_steps  = 8'(ns);
    bus.dwell      = 16'(dw);
    bus.amp        = 8'(a);
    bus.abort      = 1'b0;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    i = 0;
    while (i < exp_q.size()) begin
      check($sformatf("%s[%0d]", name, i), 64'(observed()), 64'(packed_exp(exp_q[i])));
      if (exp_q[i].ph == PhIdle) begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        break;
      end
      if (rst_on_step && exp_q[i].ph == PhStep) begin
        rst = 1'b1;
        @(negedge clk);
        check({name, "_rst"}, 64'(observed()), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check({name, "_rst_idle"}, 64'(observed()), 64'd0);
        last_freq = 16'd0;
        return;
      end
      if (noise) begin
        drive_cfg_random();
        bus.start = ($urandom_range(0, 2) == 0);
      end
      ab = (i == abort_at) ||
           (noise && (exp_q[i].ph == PhDown || exp_q[i].ph == PhDone) && $urandom_range(0, 1) == 1);
      bus.abort = ab;
      if (ab && (exp_q[i].ph == PhUp || exp_q[i].ph == PhDwell || exp_q[i].ph == PhStep)) begin
        while (exp_q.size() > i + 1) void'(exp_q.pop_back());
        push_tail(int'(exp_q[i].freq), int'(exp_q[i].amp));
      end
      @(negedge clk);
      i++;
    end
    last_freq = exp_q[exp_q.size() - 1].freq;
  endtask

  // Idle probes: start+abort together, and abort alone, must leave the block idle.
  task automatic idle_probe(input string name);
    drive_cfg_random();
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check({name, "_start_abort"}, 64'(observed()), 64'({last_freq, 8'h00, 4'b0000}));
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check({name, "_abort"}, 64'(observed()), 64'({last_freq, 8'h00, 4'b0000}));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int sf;
    int st;
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    drive_cfg_random();
    last_freq = 16'd0;
    @(negedge clk);
    @(negedge clk);
    check("reset", 64'(observed()), 64'd0);
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    @(negedge clk);
    check("reset_idle", 64'(observed()), 64'd0);

    run_sweep("basic", 100, 10, 2, 4, 3, -1, 1'b0, 1'b0);
    idle_probe("idle1");
    run_sweep("minimal", 555, 7, 0, 0, 0, -1, 1'b0, 1'b0);
    run_sweep("saturate", 16'hFFF0, 16'h0010, 3, 2, 1, -1, 1'b0, 1'b0);
    // Second dwell cycle of step 1: ramp-up (amp+1), dwell0, step, then one dwell cycle.
    run_sweep("abort_dwell", 100, 10, 2, 4, 3, (3 + 1) + 4 + 1 + 1, 1'b0, 1'b0);
    run_sweep("busy_noise", 300, 25, 3, 3, 4, -1, 1'b1, 1'b0);
    idle_probe("idle2");
    run_sweep("rst_step", 1000, 50, 2, 2, 2, -1, 1'b0, 1'b1);
    run_sweep("after_rst", 200, 20, 2, 3, 2, -1, 1'b0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      sf = ($urandom_range(0, 3) == 0) ? $urandom_range(65000, 65535) : $urandom_range(0, 65535);
      st = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 4095) : $urandom_range(0, 65535);
      run_sweep($sformatf("rand%0d", n), sf, st, $urandom_range(0, 6), $urandom_range(0, 5),
                $urandom_range(0, 10), ($urandom_range(0, 1) == 0) ? -1 : -2,
                1'b1, 1'b0);
      if ((n % 6) == 5) idle_probe($sformatf("idle_r%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sin_sweep_ctrl.md
SIN_SWEEP_CTRL -- requirements
Module: sin_sweep_ctrl

Interface
- REQ-001: Parameter FW, default 16: width of the frequency tuning word.
- REQ-002: Parameter AW, default 8: width of the amplitude code.
- REQ-003: Parameter DW, default 16: width of the dwell counter.
- REQ-004: clk  input  1  the single clock; all state updates on its rising edge.
- REQ-005: rst  input  1  reset, synchronous, active-high.
- REQ-006: start  input  1  one-cycle sweep request, sampled only in IDLE.
- REQ-007: abort  input  1  terminate an active sweep through a graceful ramp-down.
- REQ-008: start_freq  input  FW  first tuning word of the sweep.
- REQ-009: step  input  FW  unsigned increment applied per frequency step.
- REQ-010: num_steps  input  8  number of increments after the first dwell.
- REQ-011: dwell  input  DW  cycles held at each frequency; 0 is treated as 1.
- REQ-012: amp  input  AW  target amplitude code.
- REQ-013: freq_word  output  FW  tuning word driven to the sine source.
- REQ-014: amp_out  output  AW  amplitude code driven to the sine source.
- REQ-015: src_en  output  1  sine source enable.
- REQ-016: step_strobe  output  1  one-cycle pulse on each frequency increment.
- REQ-017: busy  output  1  high whenever state is not IDLE.
- REQ-018: done  output  1  one-cycle pulse at sweep completion or after an abort.

Function
- REQ-019: The FSM SHALL have states IDLE, RAMP_UP, DWELL, STEP, RAMP_DOWN and DONE.
- REQ-020: In IDLE, when start=1 and abort=0, the block SHALL latch start_freq, step, num_steps, dwell and amp into shadow registers, load freq_word=start_freq and amp_out=0, and move to RAMP_UP.
- REQ-021: Inputs SHALL be ignored outside the IDLE start cycle, so a config change mid-sweep has no effect.
- REQ-022: start while busy SHALL be ignored.
- REQ-023: start together with abort in IDLE SHALL be ignored.
- REQ-024: RAMP_UP: if amp_out equals the latched amp, the FSM SHALL go to DWELL with the dwell counter loaded; otherwise amp_out SHALL increment by 1. amp=0 therefore spends exactly 1 cycle in RAMP_UP.
- REQ-025: DWELL SHALL last exactly max(dwell,1) cycles. It then goes to STEP if step index < num_steps, else to RAMP_DOWN.
- REQ-026: STEP SHALL last 1 cycle with step_strobe=1. freq_word SHALL update to freq_word+step, saturating at 2^FW-1. The step index SHALL increment, and the FSM SHALL return to DWELL with the counter reloaded.
- REQ-027: When freq_word is saturated, each further STEP SHALL leave freq_word at 2^FW-1 and still pulse step_strobe.
- REQ-028: RAMP_DOWN: amp_out SHALL decrement by 1 per cycle. When amp_out is 0, the FSM SHALL go to DONE.
- REQ-029: DONE SHALL last 1 cycle with done=1, then return to IDLE.
- REQ-030: abort=1 in RAMP_UP, DWELL or STEP SHALL force RAMP_DOWN on the next cycle, with no step_strobe in that cycle.
- REQ-031: abort in RAMP_DOWN, DONE or IDLE SHALL have no effect.
- REQ-032: src_en SHALL be 1 in RAMP_UP, DWELL, STEP and RAMP_DOWN, and 0 in IDLE and DONE.
- REQ-033: freq_word SHALL hold its last value in RAMP_DOWN, DONE and IDLE.
- REQ-034: All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
- REQ-035: rst=1 SHALL force IDLE, and on the following cycle freq_word=0, amp_out=0, src_en=0, step_strobe=0, busy=0 and done=0.
- REQ-036: rst SHALL override start and abort in the same cycle.
- REQ-037: rst mid-sweep SHALL abandon the sweep immediately, with no ramp-down and no done pulse.

Verification
- REQ-038: start_freq=100, step=10, num_steps=2, dwell=4, amp=3 -> required response:
  - amp_out steps 0,1,2,3.
  - freq_word holds 100, 110 and 120 for 4 DWELL cycles each.
  - step_strobe pulses twice.
  - amp_out steps 3,2,1,0.
  - done pulses once, then busy=0.
- REQ-039: num_steps=0, dwell=0, amp=0 -> RAMP_UP 1 cycle, DWELL 1 cycle, RAMP_DOWN 1 cycle, done pulse, no step_strobe, freq_word=start_freq.
- REQ-040: FW=16, start_freq=0xFFF0, step=0x10, num_steps=3 -> freq_word reads 0xFFF0, then 0xFFFF for all three steps, and step_strobe pulses 3 times.
- REQ-041: abort asserted in the 2nd DWELL cycle of step 1 -> no further step_strobe, freq_word frozen, amp_out ramps to 0, done pulses once.
- REQ-042: start pulsed while busy, and start+abort pulsed together in IDLE -> both ignored, with state and outputs unchanged.
- REQ-043: rst asserted during STEP -> next cycle all outputs are 0 and state is IDLE, with no done pulse; a following start runs a full sweep.
